// File: rtl/bit_ops_pkg.sv
// -----------------------------------------------------------------------------
// bit_ops_pkg
// Shared definitions for bit-manipulation blocks.
//   shift_op_e : operation select for shifters/rotators
//     OP_ROL - rotate left
//     OP_ROR - rotate right
//     OP_SLL - logical shift left, zero fill
//     OP_SRA - arithmetic shift right, sign fill
// -----------------------------------------------------------------------------
package bit_ops_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'd0,
    OP_ROR = 2'd1,
    OP_SLL = 2'd2,
    OP_SRA = 2'd3
  } shift_op_e;

endpackage : bit_ops_pkg

// File: rtl/barrel_shifter_stage.sv
// -----------------------------------------------------------------------------
// barrel_shifter_stage
// One purely combinational stage of a barrel shifter: applies a fixed shift
// of SHIFT positions when en is set, otherwise passes data through.
//   data   : operand
//   en     : apply this stage's shift
//   op     : operation select (shift_op_e)
//   result : shifted / rotated operand
// Cascading stages with SHIFT = 1, 2, 4, ... composes any amount, including
// arithmetic right shift, because each stage refills from the current MSB,
// which still equals the original sign bit.
// -----------------------------------------------------------------------------
module barrel_shifter_stage
  import bit_ops_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so every path drives result; without it
    // the en=0 path would infer a latch.
    result = data;
    if (en) begin
      unique case (op)
        OP_ROL: result = (data << SHIFT) | (data >> (WIDTH - SHIFT));
        OP_ROR: result = (data >> SHIFT) | (data << (WIDTH - SHIFT));
        OP_SLL: result = data << SHIFT;
        OP_SRA: result = $signed(data) >>> SHIFT;
      endcase
    end
  end

endmodule : barrel_shifter_stage

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Valid/ready pipelined barrel shifter / rotator. Stage k applies a shift of
// 2^k when amount bit k is set; every stage output is registered, giving a
// latency of STAGES cycles and one beat per cycle throughput. Stalled bubbles
// collapse, so up to STAGES beats are stored under backpressure.
//   i_clock : clock, rising edge
//   i_reset : synchronous active-high reset (clears valid bits only)
//   i_valid / o_ready : input handshake
//   i_data  : operand, i_amt : amount 0..WIDTH-1, i_op : shift_op_e
//   o_valid / i_ready : output handshake
//   o_data  : result (registered)
// o_ready is a combinational function of i_ready and the stage valid bits.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
  import bit_ops_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [STAGES-1:0] i_amt,
  input  shift_op_e         i_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_data
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end

  // Stage registers.
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [STAGES-1:0] amt_q   [STAGES];
  shift_op_e         op_q    [STAGES];
  logic [STAGES-1:0] valid_q;

  // Stage inputs (stage 0 from the ports, stage k from register k-1).
  logic [WIDTH-1:0]  in_data [STAGES];
  logic [STAGES-1:0] in_amt  [STAGES];
  shift_op_e         in_op   [STAGES];
  logic [STAGES-1:0] in_valid;

  logic [WIDTH-1:0]  shifted [STAGES];
  logic [STAGES-1:0] load;

  always_comb begin
    in_data[0]  = i_data;
    in_amt[0]   = i_amt;
    in_op[0]    = i_op;
    in_valid[0] = i_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_data[k]  = data_q[k-1];
      in_amt[k]   = amt_q[k-1];
      in_op[k]    = op_q[k-1];
      in_valid[k] = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k)
    ) u_stage (
      .data   (in_data[k]),
      .en     (in_amt[k][k]),
      .op     (in_op[k]),
      .result (shifted[k])
    );
  end

  // Stage k may load when it, or any stage downstream of it, has a hole, or
  // when the output is being taken. Walking from the output back lets bubbles
  // collapse without a chained dependency on load itself.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    load     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      load[k]  = i_ready | ~all_full;
    end
  end

  assign o_ready = load[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and all stages advance together.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) valid_q[k] <= in_valid[k];
      end
    end
  end

  // NOTE: the datapath registers are deliberately not reset; they are only
  // meaningful when the matching valid bit is set, and leaving them out of
  // reset keeps the wide payload free of reset fan-out.
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        data_q[k] <= shifted[k];
        amt_q[k]  <= in_amt[k];
        op_q[k]   <= in_op[k];
      end
    end
  end

  assign o_data  = data_q[STAGES-1];
  assign o_valid = valid_q[STAGES-1];

  // The last stage's op and the already-consumed amount bits have no reader;
  // they are kept so every stage register has the same shape.
  logic unused_bits;
  always_comb begin
    unused_bits = ^{op_q[STAGES-1]};
    for (int k = 0; k < STAGES; k++) unused_bits = unused_bits ^ (^amt_q[k]);
  end

endmodule : pipelined_barrel_shifter
